// File: rtl/sp_ram_fifo_pkg.sv
// Shared constants and types for the single-port-RAM stream FIFO controller.
// Define SP_RAM_FIFO_OUTREG_EN when the RAM is built with its output register enabled.
package sp_ram_fifo_pkg;

`ifdef SP_RAM_FIFO_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int OBUF_DEPTH = LAT + 1;
    localparam int OCC_W      = $clog2(OBUF_DEPTH + 1);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WR,
        GRANT_RD
    } grant_t;

endpackage

// File: rtl/sp_ram_fifo_obuf.sv
// Small register FIFO that holds words returned by the RAM until the consumer takes them.
module sp_ram_fifo_obuf #(
    parameter int WIDTH      = 8,
    parameter int OBUF_DEPTH = 2,
    localparam int IDX_W     = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1,
    localparam int OCC_W     = $clog2(OBUF_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [OCC_W-1:0] occ,
    output logic             not_empty
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OBUF_DEPTH - 1);

    logic [WIDTH-1:0] mem [OBUF_DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            end
            if (pop) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head      = mem[rd_idx];
    assign not_empty = (occ != '0);

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// Valid/ready FIFO built on a single-port RAM: one access per cycle, fair write/read arbitration.
// SP_RAM_FIFO_OUTREG_EN selects the two-cycle RAM read latency (RAM output register on).
module sp_ram_fifo_ctrl
    import sp_ram_fifo_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEPTH-1:0] ram_address,
    output logic [WIDTH-1:0] ram_data,
    output logic             ram_data_valid,
    input  logic [WIDTH-1:0] ram_q,
    output logic [DEPTH+1:0] count
);

    localparam logic [DEPTH:0]   SIZE_C   = (DEPTH + 1)'(SIZE);
    localparam logic [DEPTH-1:0] LAST_PTR = DEPTH'(SIZE - 1);
    localparam logic [OCC_W:0]   CREDIT_C = (OCC_W + 1)'(OBUF_DEPTH);

    logic [DEPTH-1:0] wr_ptr;
    logic [DEPTH-1:0] rd_ptr;
    logic [DEPTH:0]   ram_count;
    logic [LAT-1:0]   tag_p;
    logic             last_rd;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] inflight;
    logic [OCC_W:0]   held;
    logic             not_full;
    logic             wr_req;
    logic             rd_req;
    logic             in_acc;
    logic             out_acc;
    grant_t           grant;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + OCC_W'(tag_p[i]);
    end

    // Requests are masked during reset so nothing reaches the RAM port.
    assign not_full = (ram_count < SIZE_C);
    assign held     = {1'b0, occ} + {1'b0, inflight};
    assign wr_req   = reset_n && in_valid && not_full;
    assign rd_req   = reset_n && (ram_count != '0) && (held < CREDIT_C);

    always_comb begin
        grant = GRANT_NONE;
        if (wr_req && rd_req) grant = last_rd ? GRANT_WR : GRANT_RD;
        else if (wr_req)      grant = GRANT_WR;
        else if (rd_req)      grant = GRANT_RD;
    end

    assign in_ready = reset_n && not_full && (!rd_req || grant == GRANT_WR);
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;

    always_comb begin
        ram_address    = rd_ptr;
        ram_data       = '0;
        ram_data_valid = 1'b0;
        if (grant == GRANT_WR) begin
            ram_address    = wr_ptr;
            ram_data       = in_data;
            ram_data_valid = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            tag_p     <= '0;
            last_rd   <= 1'b0;
            count     <= '0;
        end else begin
            if (grant == GRANT_WR) begin
                wr_ptr    <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                ram_count <= ram_count + 1'b1;
            end
            if (grant == GRANT_RD) begin
                rd_ptr    <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                ram_count <= ram_count - 1'b1;
            end
            // Tag marks which RAM output cycles carry read data rather than write-through.
            tag_p[0] <= (grant == GRANT_RD);
            for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
            if (wr_req && rd_req) last_rd <= (grant == GRANT_RD);
            case ({in_acc, out_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sp_ram_fifo_obuf #(
        .WIDTH      (WIDTH),
        .OBUF_DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (tag_p[LAT-1]),
        .push_data (ram_q),
        .pop       (out_acc),
        .head      (out_data),
        .occ       (occ),
        .not_empty (out_valid)
    );

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Directed bench for sp_ram_fifo_ctrl: two instances (SIZE 16 and SIZE 5) each with a behavioural single-port RAM.
`timescale 1ns/1ps
module tb_sp_ram_fifo_ctrl;
    import sp_ram_fifo_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    logic [7:0] a_in_data, a_out_data, a_ram_data, a_ram_q, a_q_p0, a_q_p1;
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ram_we;
    logic [3:0] a_ram_address;
    logic [5:0] a_count;
    logic [7:0] mem_a [16];

    logic [7:0] b_in_data, b_out_data, b_ram_data, b_ram_q, b_q_p0, b_q_p1;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ram_we;
    logic [2:0] b_ram_address;
    logic [4:0] b_count;
    logic [7:0] mem_b [8];

    sp_ram_fifo_ctrl #(.SIZE(16), .WIDTH(8), .DEPTH(4)) u_a (
        .clock(clock), .reset_n(reset_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ram_address(a_ram_address), .ram_data(a_ram_data), .ram_data_valid(a_ram_we),
        .ram_q(a_ram_q), .count(a_count)
    );

    sp_ram_fifo_ctrl #(.SIZE(5), .WIDTH(8), .DEPTH(3)) u_b (
        .clock(clock), .reset_n(reset_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ram_address(b_ram_address), .ram_data(b_ram_data), .ram_data_valid(b_ram_we),
        .ram_q(b_ram_q), .count(b_count)
    );

    // Single-port RAM models: registered read, write-through on write, optional output register.
    always @(posedge clock) begin
        if (a_ram_we) mem_a[a_ram_address] <= a_ram_data;
        a_q_p0 <= a_ram_we ? a_ram_data : mem_a[a_ram_address];
        a_q_p1 <= a_q_p0;
        if (b_ram_we) mem_b[b_ram_address] <= b_ram_data;
        b_q_p0 <= b_ram_we ? b_ram_data : mem_b[b_ram_address];
        b_q_p1 <= b_q_p0;
    end
    assign a_ram_q = (LAT == 2) ? a_q_p1 : a_q_p0;
    assign b_ram_q = (LAT == 2) ? b_q_p1 : b_q_p0;

    task automatic cyc_a(input logic iv, input logic [7:0] d, input logic ordy,
                         output logic acc_in, output logic acc_out, output logic [7:0] od);
        @(negedge clock);
        a_in_valid = iv; a_in_data = d; a_out_ready = ordy;
        #1;
        acc_in = iv && a_in_ready;
        acc_out = a_out_valid && ordy;
        od = a_out_data;
    endtask

    task automatic cyc_b(input logic iv, input logic [7:0] d, input logic ordy,
                         output logic acc_in, output logic acc_out, output logic [7:0] od);
        @(negedge clock);
        b_in_valid = iv; b_in_data = d; b_out_ready = ordy;
        #1;
        acc_in = iv && b_in_ready;
        acc_out = b_out_valid && ordy;
        od = b_out_data;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = 8'h00;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 8'h00;
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h5A; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
        @(negedge clock); #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", a_out_valid); end
        checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h want=00", a_out_data); end
        checks++; if (a_count !== 6'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", a_count); end
        checks++; if (a_ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_data_valid got=%b want=0", a_ram_we); end
        checks++; if (a_ram_address !== 4'd0) begin errors++; $display("FAIL rst_ram_address got=%0d want=0", a_ram_address); end
        checks++; if (a_ram_data !== 8'h00) begin errors++; $display("FAIL rst_ram_data got=%h want=00", a_ram_data); end
        @(negedge clock);
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b want=1", a_in_ready); end
    endtask

    task automatic test_latency();
        logic ai, ao; logic [7:0] od, d;
        logic [7:0] tx [3];
        int sent, got, first_acc, first_valid;
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
        sent = 0; got = 0; first_acc = -1; first_valid = -1;
        do_reset();
        for (int c = 0; c < 40 && got < 3; c++) begin
            d = (sent < 3) ? tx[sent] : 8'h00;
            cyc_a(sent < 3, d, 1'b1, ai, ao, od);
            if (ai && first_acc < 0) first_acc = c;
            if (a_out_valid && first_valid < 0) first_valid = c;
            if (ai) sent++;
            if (ao) begin
                checks++;
                if (od !== tx[got]) begin errors++; $display("FAIL lat_word%0d got=%h want=%h", got, od, tx[got]); end
                got++;
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL lat_words_out got=%0d want=3", got); end
        checks++;
        if (first_valid - first_acc != LAT + 2) begin
            errors++; $display("FAIL lat_first_valid got=%0d want=%0d", first_valid - first_acc, LAT + 2);
        end
        cyc_a(1'b0, 8'h00, 1'b1, ai, ao, od);
        checks++; if (a_count !== 6'd0) begin errors++; $display("FAIL lat_count_end got=%0d want=0", a_count); end
    endtask

    task automatic test_fill();
        logic ai, ao; logic [7:0] od;
        int sent, got, idle;
        sent = 0; got = 0; idle = 0;
        do_reset();
        for (int c = 0; c < 200 && idle < 8; c++) begin
            cyc_a(1'b1, 8'(sent), 1'b0, ai, ao, od);
            if (ai) begin sent++; idle = 0; end else idle++;
        end
        checks++; if (sent != 16 + OBUF_DEPTH) begin errors++; $display("FAIL full_accepts got=%0d want=%0d", sent, 16 + OBUF_DEPTH); end
        checks++; if (a_count !== 6'(16 + OBUF_DEPTH)) begin errors++; $display("FAIL full_count got=%0d want=%0d", a_count, 16 + OBUF_DEPTH); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b want=0", a_in_ready); end
        for (int c = 0; c < 200 && got < sent; c++) begin
            cyc_a(1'b0, 8'h00, 1'b1, ai, ao, od);
            if (ao) begin
                checks++;
                if (od !== 8'(got)) begin errors++; $display("FAIL full_drain%0d got=%h want=%h", got, od, 8'(got)); end
                got++;
            end
        end
        checks++; if (got != sent) begin errors++; $display("FAIL full_drain_count got=%0d want=%0d", got, sent); end
        cyc_a(1'b0, 8'h00, 1'b1, ai, ao, od);
        checks++; if (a_count !== 6'd0) begin errors++; $display("FAIL full_count_end got=%0d want=0", a_count); end
    endtask

    task automatic test_wrap();
        logic ai, ao; logic [7:0] od, want;
        logic [3:0] addr_want;
        int sent, got;
        sent = 0; got = 0;
        do_reset();
        for (int c = 0; c < 400 && got < 40; c++) begin
            cyc_b(sent < 40, 8'(sent * 7 + 3), 1'b1, ai, ao, od);
            if (ai) begin
                addr_want = {1'b1, 3'(sent % 5)};
                checks++;
                if ({b_ram_we, b_ram_address} !== addr_want) begin
                    errors++; $display("FAIL wrap_wr_addr%0d got=%h want=%h", sent, {b_ram_we, b_ram_address}, addr_want);
                end
                sent++;
            end
            if (ao) begin
                want = 8'(got * 7 + 3);
                checks++;
                if (od !== want) begin errors++; $display("FAIL wrap_word%0d got=%h want=%h", got, od, want); end
                got++;
            end
        end
        checks++; if (got != 40) begin errors++; $display("FAIL wrap_words_out got=%0d want=40", got); end
    endtask

    task automatic test_back_to_back();
        logic ai, ao; logic [7:0] od, want;
        logic prev_we;
        int sent, n_in, n_out, bad_alt;
        sent = 0; n_in = 0; n_out = 0; bad_alt = 0; prev_we = 1'b0;
        do_reset();
        for (int c = 0; c < 50 && sent < 8; c++) begin
            cyc_a(1'b1, 8'(8'h40 + sent), 1'b0, ai, ao, od);
            if (ai) begin exp_q.push_back(8'(8'h40 + sent)); sent++; end
        end
        for (int c = 0; c < 6; c++) cyc_a(1'b0, 8'h00, 1'b0, ai, ao, od);
        for (int c = 0; c < 24; c++) begin
            cyc_a(1'b1, 8'(8'h40 + sent), 1'b1, ai, ao, od);
            if (c > 8 && a_ram_we === prev_we) bad_alt++;
            prev_we = a_ram_we;
            if (ai) begin
                exp_q.push_back(8'(8'h40 + sent)); sent++;
                if (c >= 8) n_in++;
            end
            if (ao) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (od !== want) begin errors++; $display("FAIL b2b_word got=%h want=%h", od, want); end
                if (c >= 8) n_out++;
            end
        end
        checks++; if (bad_alt != 0) begin errors++; $display("FAIL b2b_alternate repeats=%0d want=0", bad_alt); end
        checks++; if (n_in != 8) begin errors++; $display("FAIL b2b_in_rate got=%0d want=8", n_in); end
        checks++; if (n_out != 8) begin errors++; $display("FAIL b2b_out_rate got=%0d want=8", n_out); end
    endtask

    task automatic test_stall();
        logic ai, ao, iv, ordy; logic [7:0] od, want;
        int sent, got, max_occ;
        sent = 0; got = 0; max_occ = 0;
        do_reset();
        for (int c = 0; c < 600 && got < 40; c++) begin
            iv = (sent < 40) && ($urandom_range(3) != 0);
            ordy = $urandom_range(1) != 0;
            cyc_a(iv, 8'(8'hC0 + sent), ordy, ai, ao, od);
            if (int'(u_a.u_obuf.occ) > max_occ) max_occ = int'(u_a.u_obuf.occ);
            if (ai) begin exp_q.push_back(8'(8'hC0 + sent)); sent++; end
            if (ao) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (od !== want) begin errors++; $display("FAIL stall_word%0d got=%h want=%h", got, od, want); end
                got++;
            end
        end
        checks++; if (got != 40) begin errors++; $display("FAIL stall_words_out got=%0d want=40", got); end
        checks++; if (max_occ > OBUF_DEPTH) begin errors++; $display("FAIL stall_obuf_occ got=%0d max=%0d", max_occ, OBUF_DEPTH); end
        cyc_a(1'b0, 8'h00, 1'b0, ai, ao, od);
        checks++; if (a_count !== 6'd0) begin errors++; $display("FAIL stall_count_end got=%0d want=0", a_count); end
    endtask

    task automatic test_reset_mid();
        logic ai, ao; logic [7:0] od;
        int sent, got;
        sent = 0; got = 0;
        do_reset();
        for (int c = 0; c < 50 && sent < 7; c++) begin
            cyc_a(1'b1, 8'(8'h70 + sent), 1'b0, ai, ao, od);
            if (ai) sent++;
        end
        for (int c = 0; c < 4; c++) cyc_a(1'b0, 8'h00, 1'b0, ai, ao, od);
        checks++; if (a_count !== 6'd7) begin errors++; $display("FAIL mid_count_held got=%0d want=7", a_count); end
        a_in_valid = 1'b1; a_in_data = 8'h99;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b want=0", a_out_valid); end
        checks++; if (a_count !== 6'd0) begin errors++; $display("FAIL mid_count got=%0d want=0", a_count); end
        checks++; if (a_ram_we !== 1'b0) begin errors++; $display("FAIL mid_ram_data_valid got=%b want=0", a_ram_we); end
        @(negedge clock);
        a_in_valid = 1'b0;
        reset_n = 1'b1;
        for (int c = 0; c < 40 && got < 1; c++) begin
            cyc_a(sent < 8, 8'hAA, 1'b1, ai, ao, od);
            if (ai) sent = 8;
            if (ao) begin
                checks++;
                if (od !== 8'hAA) begin errors++; $display("FAIL mid_first_out got=%h want=aa", od); end
                got++;
            end
        end
        checks++; if (got != 1) begin errors++; $display("FAIL mid_out_seen got=%0d want=1", got); end
        cyc_a(1'b0, 8'h00, 1'b1, ai, ao, od);
        checks++; if (a_count !== 6'd0) begin errors++; $display("FAIL mid_count_end got=%0d want=0", a_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
